onehot_scan_decoder: RTL

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable and autonomous scan modes. It drives the board LED bank or a column-select bus. In direct mode it latches a binary code. In scan mode it walks the active output up, down or back and forth, stepping once per prescaled tick. It is the clocked successor to the team's combinational 3-to-8 decoder.

---
 rtl/onehot_scan_decoder_pkg.sv | 26 ++
 rtl/onehot_scan_decoder_if.sv | 24 ++
 rtl/onehot_scan_decoder_scan_tick_gen.sv | 36 +++
 rtl/onehot_scan_decoder.sv | 111 +++++++++++
 4 files changed

// File: rtl/onehot_scan_decoder_pkg.sv
// Shared types and helpers for the registered one-hot scan decoder.
package onehot_pkg;

  localparam int unsigned ONEHOT_MAX_W = 256;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Callers size-cast the result down to their own output width.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx);
    logic [ONEHOT_MAX_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// Control/status bundle between a host and the one-hot scan decoder.
interface onehot_scan_decoder_if #(
  parameter int unsigned SEL_W = 3
);
  localparam int unsigned OUT_W = 2 ** SEL_W;

  logic             en;
  logic [1:0]       mode;
  logic             sel_valid;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] idx;
  logic             tick_o;

  modport master (
    output en, mode, sel_valid, sel,
    input  out, idx, tick_o
  );

  modport slave (
    input  en, mode, sel_valid, sel,
    output out, idx, tick_o
  );
endinterface

// File: rtl/onehot_scan_decoder_scan_tick_gen.sv
// Prescaler producing a combinational step strobe on the last count of each period.
module scan_tick_gen #(
  parameter int unsigned PRESCALE = 13_500_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic run,
  output logic tick
);
  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear dominates so a load or mode change never coincides with a step.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with direct and scan modes.
// Bounce mode (11) is built only when ONEHOT_SCAN_BOUNCE_EN is defined; otherwise 11 acts as direct.
module onehot_scan_decoder
  import onehot_pkg::*;
#(
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned PRESCALE = 13_500_000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  onehot_scan_decoder_if.slave   bus
);
  localparam int unsigned OUT_W = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(OUT_W - 1);

  mode_e            mode_cur, mode_q;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             tick_q, tick_d;
  logic             mode_chg, scanning, tick_clr, tick_run, step;
`ifdef ONEHOT_SCAN_BOUNCE_EN
  dir_e             dir_q, dir_d;
`endif

  assign mode_cur = mode_e'(bus.mode);
  assign mode_chg = (mode_cur != mode_q);

  always_comb begin
    scanning = (mode_cur == MODE_UP) || (mode_cur == MODE_DOWN);
`ifdef ONEHOT_SCAN_BOUNCE_EN
    scanning = scanning || (mode_cur == MODE_BOUNCE);
`endif
  end

  assign tick_run = bus.en & scanning;
  assign tick_clr = ~bus.en | ~scanning | mode_chg | bus.sel_valid;

  scan_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (tick_clr),
    .run     (tick_run),
    .tick    (step)
  );

  always_comb begin
    idx_d  = idx_q;
    out_d  = '0;
    tick_d = 1'b0;
`ifdef ONEHOT_SCAN_BOUNCE_EN
    dir_d  = mode_chg ? DIR_UP : dir_q;
`endif
    if (bus.en) begin
      if (bus.sel_valid) begin
        idx_d = bus.sel;
      end else if (step) begin
        tick_d = 1'b1;
        case (mode_cur)
          MODE_UP:   idx_d = idx_q + SEL_W'(1);
          MODE_DOWN: idx_d = idx_q - SEL_W'(1);
`ifdef ONEHOT_SCAN_BOUNCE_EN
          // Turn around at the ends without dwelling on the end index twice.
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (idx_q == IDX_MAX) begin
                dir_d = DIR_DOWN;
                idx_d = idx_q - SEL_W'(1);
              end else begin
                idx_d = idx_q + SEL_W'(1);
              end
            end else begin
              if (idx_q == '0) begin
                dir_d = DIR_UP;
                idx_d = idx_q + SEL_W'(1);
              end else begin
                idx_d = idx_q - SEL_W'(1);
              end
            end
          end
`endif
          default: idx_d = idx_q;
        endcase
      end
      out_d = OUT_W'(onehot(32'(idx_d)));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx_q  <= '0;
      out_q  <= '0;
      tick_q <= 1'b0;
      mode_q <= MODE_DIRECT;
`ifdef ONEHOT_SCAN_BOUNCE_EN
      dir_q  <= DIR_UP;
`endif
    end else begin
      idx_q  <= idx_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      mode_q <= mode_cur;
`ifdef ONEHOT_SCAN_BOUNCE_EN
      dir_q  <= dir_d;
`endif
    end
  end

  assign bus.out    = out_q;
  assign bus.idx    = idx_q;
  assign bus.tick_o = tick_q;
endmodule
